// File: rtl/lcd_window_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_window_addr_gen
//  Purpose  : Command decoder and framebuffer write-address generator.
//             Consumes the command / parameter / pixel latch stream from
//             lcd_rx_if, tracks the column (0x2A) and page (0x2B) window,
//             and converts every RGB565 pixel of a memory write (0x2C/0x3C)
//             into one linear framebuffer write. The cursor wraps inside the
//             window; pixels that land outside the panel are clipped but
//             still advance the cursor.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk            in   1       video clock
//    i_rst_n          in   1       asynchronous active-low reset
//    i_command        in   8       command byte
//    i_command_latch  in   1       strobe, i_command valid
//    i_param          in   8       parameter byte
//    i_param_latch    in   1       strobe, i_param valid
//    i_rgb565         in   16      pixel data
//    i_rgb565_latch   in   1       strobe, i_rgb565 valid
//    o_wr_en          out  1       framebuffer write strobe
//    o_wr_addr        out  ADDR_W  linear address row*H_RES+col
//    o_wr_data        out  16      RGB565 write data
//    o_ramwr_start    out  1       pulse when 0x2C is accepted
// ============================================================================
module lcd_window_addr_gen #(
    parameter int H_RES  = 480,
    parameter int V_RES  = 320,
    parameter int ADDR_W = 18
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_command,
    input  logic              i_command_latch,
    input  logic [7:0]        i_param,
    input  logic              i_param_latch,
    input  logic [15:0]       i_rgb565,
    input  logic              i_rgb565_latch,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [15:0]       o_wr_data,
    output logic              o_ramwr_start
);

    localparam logic [7:0]  c_CMD_CASET   = 8'h2A;
    localparam logic [7:0]  c_CMD_PASET   = 8'h2B;
    localparam logic [7:0]  c_CMD_RAMWR   = 8'h2C;
    localparam logic [7:0]  c_CMD_RAMWRC  = 8'h3C;
    localparam logic [15:0] c_H_RES       = 16'(H_RES);
    localparam logic [15:0] c_V_RES       = 16'(V_RES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CASET = 2'd1,
        S_PASET = 2'd2,
        S_RAMWR = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_nxt;

    // Window and cursor
    logic [15:0] r_sc;
    logic [15:0] r_ec;
    logic [15:0] r_sp;
    logic [15:0] r_ep;
    logic [15:0] r_col;
    logic [15:0] r_row;

    // First three parameter bytes; the fourth arrives on i_param directly
    logic [7:0]  r_p0;
    logic [7:0]  r_p1;
    logic [7:0]  r_p2;

    // Strobe qualification with command > param > pixel priority
    logic        w_in_param_state;
    logic        w_take_param;
    logic        w_take_pixel;
    logic        w_in_panel;

    assign w_in_param_state = (r_state == S_CASET) || (r_state == S_PASET);
    assign w_take_param     = !i_command_latch && i_param_latch && w_in_param_state;
    assign w_take_pixel     = !i_command_latch && !i_param_latch && i_rgb565_latch
                              && (r_state == S_RAMWR);
    assign w_in_panel       = (r_col < c_H_RES) && (r_row < c_V_RES);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (i_command_latch) begin
            // Any command restarts parameter collection
            w_idx_nxt = 2'd0;
            case (i_command)
                c_CMD_CASET:  w_state_nxt = S_CASET;
                c_CMD_PASET:  w_state_nxt = S_PASET;
                c_CMD_RAMWR:  w_state_nxt = S_RAMWR;
                c_CMD_RAMWRC: w_state_nxt = S_RAMWR;
                default:      w_state_nxt = S_IDLE;
            endcase
        end else if (w_take_param) begin
            if (r_idx == 2'd3) begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 2'd0;
            end else begin
                w_idx_nxt   = r_idx + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Window, cursor and write-port datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sc          <= 16'd0;
            r_ec          <= c_H_RES - 16'd1;
            r_sp          <= 16'd0;
            r_ep          <= c_V_RES - 16'd1;
            r_col         <= 16'd0;
            r_row         <= 16'd0;
            r_p0          <= 8'd0;
            r_p1          <= 8'd0;
            r_p2          <= 8'd0;
            o_wr_en       <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= 16'd0;
            o_ramwr_start <= 1'b0;
        end else begin
            o_wr_en       <= 1'b0;
            o_ramwr_start <= 1'b0;

            if (i_command_latch) begin
                if (i_command == c_CMD_RAMWR) begin
                    r_col         <= r_sc;
                    r_row         <= r_sp;
                    o_ramwr_start <= 1'b1;
                end
            end else if (w_take_param) begin
                case (r_idx)
                    2'd0: r_p0 <= i_param;
                    2'd1: r_p1 <= i_param;
                    2'd2: r_p2 <= i_param;
                    default: begin
                        // Start and end commit together so the window is
                        // never observed half-updated
                        if (r_state == S_CASET) begin
                            r_sc <= {r_p0, r_p1};
                            r_ec <= {r_p2, i_param};
                        end else begin
                            r_sp <= {r_p0, r_p1};
                            r_ep <= {r_p2, i_param};
                        end
                    end
                endcase
            end else if (w_take_pixel) begin
                if (w_in_panel) begin
                    o_wr_en   <= 1'b1;
                    o_wr_addr <= ADDR_W'(32'(r_row) * 32'(H_RES) + 32'(r_col));
                    o_wr_data <= i_rgb565;
                end
                // >= rather than == keeps a degenerate window (start > end)
                // bounded to a single column/row instead of running away
                if (r_col >= r_ec) begin
                    r_col <= r_sc;
                    if (r_row >= r_ep) begin
                        r_row <= r_sp;
                    end else begin
                        r_row <= r_row + 16'd1;
                    end
                end else begin
                    r_col <= r_col + 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/lcd_window_addr_gen.md
Name: lcd_window_addr_gen

Overview:
Command decoder and write-address generator between lcd_rx_if and the framebuffer write port, in the clk_video domain. It consumes the decoded command/param/pixel latch stream, tracks the controller's column/page window (0x2A/0x2B), and turns each RGB565 pixel inside a memory write (0x2C/0x3C) into one linear framebuffer write. The cursor wraps inside the window, and pixels outside the panel are clipped.

Parameters:
H_RES, 480, panel width in pixels; also the linear address row stride
V_RES, 320, panel height in pixels
ADDR_W, 18, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES

Ports:
i_clk  in  1  video clock
i_rst_n  in  1  asynchronous active-low reset
i_command  in  8  command byte from lcd_rx_if
i_command_latch  in  1  one-cycle strobe, i_command valid
i_param  in  8  parameter byte
i_param_latch  in  1  one-cycle strobe, i_param valid
i_rgb565  in  16  pixel data
i_rgb565_latch  in  1  one-cycle strobe, i_rgb565 valid
o_wr_en  out  1  framebuffer write strobe
o_wr_addr  out  ADDR_W  linear address, row*H_RES+col
o_wr_data  out  16  RGB565 data for the write
o_ramwr_start  out  1  one-cycle pulse when 0x2C is accepted

Behaviour:
- Reset is asynchronous and active-low; deassertion is used as delivered by the video-domain reset.
- Reset values:
  - all outputs 0
  - state IDLE
  - window SC=0, EC=H_RES-1, SP=0, EP=V_RES-1
  - cursor col=0, row=0
  - parameter shift registers 0
- Window and cursor registers are 16-bit unsigned.
- States: IDLE, CASET, PASET, RAMWR. CASET and PASET carry a 2-bit parameter index.
- Same-cycle strobe priority: command > param > pixel. Lower-priority strobes in that cycle are dropped.
- Command accepted, from any state (aborts any partial parameter sequence, never writes the window):
  - 0x2A -> CASET, idx=0
  - 0x2B -> PASET, idx=0
  - 0x2C -> RAMWR; col<=SC, row<=SP; o_ramwr_start=1 the next cycle
  - 0x3C -> RAMWR; cursor unchanged
  - any other byte -> IDLE
- Parameter in CASET/PASET:
  - bytes are collected in order: start hi, start lo, end hi, end lo
  - on the 4th byte the start/end pair ({hi,lo}) commits atomically, then state -> IDLE
  - parameters received in IDLE or RAMWR are ignored
- Pixel in RAMWR, one cycle after i_rgb565_latch:
  - if col<H_RES and row<V_RES: o_wr_en=1, o_wr_addr=row*H_RES+col (ADDR_W bits), o_wr_data=i_rgb565
  - otherwise o_wr_en=0 (clipped), but the cursor still advances
- Cursor advance:
  - if col>=EC: col<=SC; then if row>=EP, row<=SP, else row<=row+1
  - otherwise col<=col+1
  - the >= compare makes a degenerate window (SC>EC or SP>EP) write a single column/row repeatedly; no hang
- Pixels outside RAMWR are ignored.
- o_wr_en and o_ramwr_start are single-cycle pulses.
- o_wr_addr and o_wr_data hold their last value when o_wr_en=0.
- Fixed latency: strobe to output is 1 cycle. The block accepts one strobe per cycle with no stall and has no backpressure.
- Address arithmetic: the multiply may be replaced by an incrementally maintained row base. Results must be identical, including after a window change followed by 0x3C.
- Reset mid-RAMWR or mid-parameter: window reverts to full panel, state IDLE, no write emitted after reset assertion.

Test Plan:
- Reset, then 0x2C followed by 3 pixels 0xF800,0x07E0,0x001F -> ramwr_start pulse; writes at addr 0,1,2 with matching data, each 1 cycle after its strobe.
- 0x2A {00,0A,00,0C}, 0x2B {00,05,00,06}, 0x2C, 7 pixels -> addrs 2410,2411,2412,2890,2891,2892, then wrap to 2410.
- 0x2A with only 2 params, then 0x2C, 1 pixel -> window unchanged; write at addr 0.
- 0x2A {01,DE,01,E1} (478..481), 0x2C, 5 pixels -> writes at 478,479; 2 pixels clipped (no wr_en); 5th pixel at 480+478=958.
- 0x2C, 2 pixels, unrelated command 0x00, 0x3C, 1 pixel -> third write at addr 2 (cursor preserved); pixel sent during IDLE produces no write.
- Command and pixel strobes in the same cycle -> command taken, pixel dropped. i_rst_n low mid-RAMWR -> outputs 0 immediately; after release, 0x2C writes at addr 0.
